// File: rtl/i2s_in_pkg.sv
// Shared audio constants and the frame layout handed from the deserializer to the FIFO.
// Word width, FIFO width and FIFO address width live here so every audio block agrees on them.
package i2s_in_pkg;

    localparam int WORD_W  = 16;
    localparam int FIFO_W  = 32;
    localparam int FIFO_AW = 3;
    localparam int CNT_W   = 5;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [WORD_W-1:0] left;
        logic [WORD_W-1:0] right;
    } frame_t;

endpackage

// File: rtl/fifo.sv
// Shared synchronous FIFO: power-of-two depth, first-word-fall-through read port.
// A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
module fifo #(
    parameter int WIDTH = 32,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic             doPush;
    logic             doPop;

    always_comb begin
        full_o  = (count_q == (AW+1)'(DEPTH));
        empty_o = (count_q == '0);
        doPop   = pop_i && !empty_o;
        doPush  = push_i && (!full_o || doPop);
        rdata_o = mem_q[rdPtr_q];
    end

    // Storage is left unreset; consumers gate the read data with empty_o.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            unique case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/i2s_in_deserializer.sv
// I2S serial-to-parallel stage: shifts sd on each sck strobe, splits words on WS edges,
// pairs a left and right word into a frame and pulses push the cycle after it completes.
module deserializer
    import i2s_in_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   sample_i,
    input  logic   ws_i,
    input  logic   sd_i,
    output logic   push_o,
    output frame_t frame_o,
    output logic   frameErr_o
);

    logic [WORD_W-1:0] shift_q;
    logic [WORD_W-1:0] shift_d;
    logic [CNT_W-1:0]  bitCnt_q;
    logic [WORD_W-1:0] left_q;
    logic [WORD_W-1:0] right_q;
    logic              wsPrev_q;
    logic              primed_q;
    logic              firstWord_q;
    logic              leftValid_q;
    logic              push_q;
    logic              frameErr_q;
    logic              wsEdge;
    logic              wordFull;

    // The bit arriving with a WS edge is the LSB of the word that just ended, so a
    // complete word shows fifteen counted bits before the edge sample.
    always_comb begin
        shift_d  = {shift_q[WORD_W-2:0], sd_i};
        wsEdge   = sample_i && primed_q && (ws_i != wsPrev_q);
        wordFull = (bitCnt_q == CNT_W'(WORD_W - 1));
    end

    // primed_q keeps the reset value of wsPrev_q from faking an edge; firstWord_q
    // lets the partial word seen after reset drop silently instead of flagging an error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q     <= '0;
            bitCnt_q    <= '0;
            left_q      <= '0;
            right_q     <= '0;
            wsPrev_q    <= 1'b0;
            primed_q    <= 1'b0;
            firstWord_q <= 1'b1;
            leftValid_q <= 1'b0;
            push_q      <= 1'b0;
            frameErr_q  <= 1'b0;
        end else begin
            push_q     <= 1'b0;
            frameErr_q <= 1'b0;
            if (sample_i) begin
                shift_q  <= shift_d;
                wsPrev_q <= ws_i;
                primed_q <= 1'b1;
                if (wsEdge) begin
                    bitCnt_q    <= '0;
                    firstWord_q <= 1'b0;
                    if (wordFull) begin
                        if (!wsPrev_q) begin
                            left_q      <= shift_d;
                            leftValid_q <= 1'b1;
                        end else begin
                            right_q <= shift_d;
                            if (leftValid_q) begin
                                push_q      <= 1'b1;
                                leftValid_q <= 1'b0;
                            end
                        end
                    end else begin
                        leftValid_q <= 1'b0;
                        if (!firstWord_q) begin
                            frameErr_q <= 1'b1;
                        end
                    end
                end else if (bitCnt_q != CNT_MAX) begin
                    bitCnt_q <= bitCnt_q + 1'b1;
                end
            end
        end
    end

    assign push_o     = push_q;
    assign frame_o    = {left_q, right_q};
    assign frameErr_o = frameErr_q;

endmodule

// File: rtl/i2s_in.sv
// I2S receiver: deserializes stereo frames into an 8-deep FIFO drained by the Filter
// over an rts/rtr handshake, with sticky overrun and framing-error flags.
module i2s_in
    import i2s_in_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck_inp,
    input  logic              sck_transition,
    output logic              i2si_sck,
    input  logic              i2si_ws,
    input  logic              i2si_sd,
    output logic              filt_rts,
    input  logic              filt_rtr,
    output logic [FIFO_W-1:0] filt_data,
    input  logic              trig_fifo_overrun,
    output logic              ro_fifo_overrun,
    input  logic              trig_frame_err,
    output logic              ro_frame_err
);

    frame_t            frame;
    logic              push;
    logic              frameErr;
    logic              pop;
    logic              full;
    logic              empty;
    logic [FIFO_W-1:0] rdata;
    logic              overrunSet;
    logic              fifoOverrun_q;
    logic              frameErr_q;

    assign i2si_sck = sck_inp;

    deserializer uDeserializer (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_i   (sck_transition),
        .ws_i       (i2si_ws),
        .sd_i       (i2si_sd),
        .push_o     (push),
        .frame_o    (frame),
        .frameErr_o (frameErr)
    );

    fifo #(
        .WIDTH (FIFO_W),
        .AW    (FIFO_AW)
    ) uFifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (frame),
        .pop_i   (pop),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty)
    );

    // An empty FIFO presents zero so nothing stale is visible after reset.
    always_comb begin
        filt_rts   = !empty;
        filt_data  = empty ? '0 : rdata;
        pop        = filt_rts && filt_rtr;
        overrunSet = push && full && !pop;
    end

    // Set wins over the software clear when both land in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifoOverrun_q <= 1'b0;
            frameErr_q    <= 1'b0;
        end else begin
            if (overrunSet) begin
                fifoOverrun_q <= 1'b1;
            end else if (trig_fifo_overrun) begin
                fifoOverrun_q <= 1'b0;
            end
            if (frameErr) begin
                frameErr_q <= 1'b1;
            end else if (trig_frame_err) begin
                frameErr_q <= 1'b0;
            end
        end
    end

    assign ro_fifo_overrun = fifoOverrun_q;
    assign ro_frame_err    = frameErr_q;

endmodule

// File: tb/tb_i2s_in.sv
// Directed bench for i2s_in: streams I2S frames, records every Filter transfer and
// compares deliveries and sticky flags against hand-computed values.
module tb_i2s_in;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sck_inp;
    logic        sck_transition;
    logic        i2si_ws;
    logic        i2si_sd;
    logic        filt_rtr;
    logic        trig_fifo_overrun;
    logic        trig_frame_err;
    logic        i2si_sck;
    logic        filt_rts;
    logic [31:0] filt_data;
    logic        ro_fifo_overrun;
    logic        ro_frame_err;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] got[$];
    logic [31:0] expQ[$];

    always #5 clk = ~clk;

    i2s_in dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .sck_inp           (sck_inp),
        .sck_transition    (sck_transition),
        .i2si_sck          (i2si_sck),
        .i2si_ws           (i2si_ws),
        .i2si_sd           (i2si_sd),
        .filt_rts          (filt_rts),
        .filt_rtr          (filt_rtr),
        .filt_data         (filt_data),
        .trig_fifo_overrun (trig_fifo_overrun),
        .ro_fifo_overrun   (ro_fifo_overrun),
        .trig_frame_err    (trig_frame_err),
        .ro_frame_err      (ro_frame_err)
    );

    // Inputs change on the falling edge; just after it they hold until the next rising edge.
    always @(negedge clk) begin
        #1;
        if (rst_n && filt_rts && filt_rtr) begin
            got.push_back(filt_data);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ws, input logic sd);
        @(negedge clk);
        i2si_ws        = ws;
        i2si_sd        = sd;
        sck_transition = 1'b1;
        sck_inp        = 1'b1;
        @(negedge clk);
        sck_transition = 1'b0;
        sck_inp        = 1'b0;
    endtask

    task automatic sendFrame(input logic [15:0] l, input logic [15:0] r);
        for (int i = 15; i >= 1; i--) applyStimulus(1'b0, l[i]);
        applyStimulus(1'b1, l[0]);
        for (int i = 15; i >= 1; i--) applyStimulus(1'b1, r[i]);
        applyStimulus(1'b0, r[0]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic compareQueue(input string tag);
        checkOutput({tag, "_count"}, 32'(got.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++) begin
            checkOutput($sformatf("%s_%0d", tag, i), (i < got.size()) ? got[i] : 32'hxxxxxxxx, expQ[i]);
        end
    endtask

    initial begin
        rst_n = 1'b0; sck_inp = 1'b0; sck_transition = 1'b0;
        i2si_ws = 1'b0; i2si_sd = 1'b0; filt_rtr = 1'b0;
        trig_fifo_overrun = 1'b0; trig_frame_err = 1'b0;
        idle(3);
        checkOutput("reset_rts", 32'(filt_rts), 32'd0);
        checkOutput("reset_data", filt_data, 32'd0);
        checkOutput("reset_overrun", 32'(ro_fifo_overrun), 32'd0);
        checkOutput("reset_frame_err", 32'(ro_frame_err), 32'd0);
        rst_n = 1'b1;
        idle(2);

        sck_inp = 1'b1; #1;
        checkOutput("sck_pass_hi", 32'(i2si_sck), 32'd1);
        sck_inp = 1'b0; #1;
        checkOutput("sck_pass_lo", 32'(i2si_sck), 32'd0);

        // Three clean frames streamed straight through to the Filter.
        filt_rtr = 1'b1;
        got.delete();
        repeat (3) sendFrame(16'hA5C3, 16'h1234);
        idle(6);
        expQ = '{32'hA5C31234, 32'hA5C31234, 32'hA5C31234};
        compareQueue("stream");
        checkOutput("stream_overrun", 32'(ro_fifo_overrun), 32'd0);
        checkOutput("stream_frame_err", 32'(ro_frame_err), 32'd0);

        // Nine frames with the Filter stalled: eight held, the ninth dropped.
        filt_rtr = 1'b0;
        got.delete();
        for (int i = 0; i < 9; i++) sendFrame(16'h1000 + 16'(i), 16'h2000 + 16'(i));
        idle(3);
        checkOutput("full_overrun", 32'(ro_fifo_overrun), 32'd1);
        checkOutput("full_rts", 32'(filt_rts), 32'd1);
        checkOutput("full_head", filt_data, 32'h10002000);
        checkOutput("full_no_xfer", 32'(got.size()), 32'd0);
        @(negedge clk); trig_fifo_overrun = 1'b1;
        @(negedge clk); trig_fifo_overrun = 1'b0;
        checkOutput("overrun_cleared", 32'(ro_fifo_overrun), 32'd0);

        // Clear pulse lands on the same cycle as a dropped push.
        sendFrame(16'h3000, 16'h4000);
        trig_fifo_overrun = 1'b1;
        @(negedge clk); trig_fifo_overrun = 1'b0;
        checkOutput("set_beats_clear", 32'(ro_fifo_overrun), 32'd1);
        @(negedge clk); trig_fifo_overrun = 1'b1;
        @(negedge clk); trig_fifo_overrun = 1'b0;
        checkOutput("overrun_cleared2", 32'(ro_fifo_overrun), 32'd0);

        // Pop coincides with a push on the full FIFO: accepted, no overrun.
        sendFrame(16'h5000, 16'h6000);
        filt_rtr = 1'b1;
        @(negedge clk); filt_rtr = 1'b0;
        idle(2);
        checkOutput("pushpop_overrun", 32'(ro_fifo_overrun), 32'd0);
        checkOutput("pushpop_still_full", 32'(filt_rts), 32'd1);
        filt_rtr = 1'b1;
        idle(30);
        filt_rtr = 1'b0;
        expQ = '{32'h10002000, 32'h10012001, 32'h10022002, 32'h10032003, 32'h10042004,
                 32'h10052005, 32'h10062006, 32'h10072007, 32'h50006000};
        compareQueue("drain");
        checkOutput("drain_rts", 32'(filt_rts), 32'd0);

        // A 15-bit left word is a framing error; its frame never reaches the Filter.
        filt_rtr = 1'b1;
        got.delete();
        for (int i = 15; i >= 2; i--) applyStimulus(1'b0, i[0]);
        applyStimulus(1'b1, 1'b1);
        for (int i = 15; i >= 1; i--) applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0);
        sendFrame(16'h1111, 16'h2222);
        idle(6);
        checkOutput("short_frame_err", 32'(ro_frame_err), 32'd1);
        expQ = '{32'h11112222};
        compareQueue("short");
        @(negedge clk); trig_frame_err = 1'b1;
        @(negedge clk); trig_frame_err = 1'b0;
        checkOutput("frame_err_cleared", 32'(ro_frame_err), 32'd0);

        // Reset in the middle of a right word with three frames queued.
        filt_rtr = 1'b0;
        got.delete();
        for (int i = 1; i <= 3; i++) sendFrame(16'h7000 + 16'(i), 16'h8000 + 16'(i));
        idle(2);
        checkOutput("queued_head", filt_data, 32'h70018001);
        for (int i = 15; i >= 1; i--) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0);
        @(negedge clk); rst_n = 1'b0; #1;
        checkOutput("async_reset_rts", 32'(filt_rts), 32'd0);
        @(negedge clk);
        checkOutput("reset_next_rts", 32'(filt_rts), 32'd0);
        checkOutput("reset_next_data", filt_data, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0);
        filt_rtr = 1'b1;
        sendFrame(16'h9A9A, 16'h5B5B);
        sendFrame(16'h9A9A, 16'h5B5B);
        idle(6);
        expQ = '{32'h9A9A5B5B, 32'h9A9A5B5B};
        compareQueue("after_reset");
        checkOutput("after_reset_frame_err", 32'(ro_frame_err), 32'd0);
        checkOutput("after_reset_overrun", 32'(ro_fifo_overrun), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_in.md
I2S_IN -- requirements
Module: i2s_in

Interface
REQ-001 SHALL have port clk, input, 1: master clock; all logic on posedge clk.
REQ-002 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-003 SHALL have port sck_inp, input, 1: serial clock, already in the clk domain.
REQ-004 SHALL have port sck_transition, input, 1: one-clk pulse marking each sck rising edge; the only sample strobe.
REQ-005 SHALL have port i2si_sck, output, 1: equal to sck_inp (combinational pass-through).
REQ-006 SHALL have port i2si_ws, input, 1: word select, 0 = left, 1 = right; clk-domain synchronous.
REQ-007 SHALL have port i2si_sd, input, 1: serial data, MSB first; clk-domain synchronous.
REQ-008 SHALL have port filt_rts, output, 1: ready-to-send to Filter.
REQ-009 SHALL have port filt_rtr, input, 1: ready-to-read from Filter.
REQ-010 SHALL have port filt_data, output, 32: {left[15:0], right[15:0]}.
REQ-011 SHALL have port trig_fifo_overrun, input, 1: clears ro_fifo_overrun.
REQ-012 SHALL have port ro_fifo_overrun, output, 1: sticky, frame dropped because FIFO full.
REQ-013 SHALL have port trig_frame_err, input, 1: clears ro_frame_err.
REQ-014 SHALL have port ro_frame_err, output, 1: sticky, word with bit count other than 16 received.

Function
REQ-015 SHALL sample i2si_ws and i2si_sd only in cycles where sck_transition=1; all other cycles hold state.
REQ-016 SHALL shift i2si_sd into a 16-bit shift register (LSB end) on every sample and increment a 5-bit bit counter that saturates at 31.
REQ-017 SHALL record the last sampled ws as ws_prev; a WS edge is a sample where i2si_ws differs from ws_prev.
REQ-018 SHALL on a WS edge treat the bit shifted in that same sample as the LSB of the word just ended (I2S one-bit delay), so the word equals the shift register contents including that bit.
REQ-019 SHALL on a WS edge reset the bit counter so the next sample counts as bit 1 (MSB of the new word).
REQ-020 SHALL at a WS edge with count = 16 store the word to the left holding register if ws_prev=0, otherwise to the right holding register.
REQ-021 SHALL at a WS edge with count other than 16 discard the word, set ro_frame_err, and clear left_valid.
REQ-022 SHALL set left_valid when a left word is stored, and clear it when a frame is pushed or dropped.
REQ-023 SHALL treat a 1->0 WS edge with a valid right word and left_valid=1 as frame complete.
REQ-024 SHALL push {left,right} into the FIFO in the clk cycle after a complete-frame sample.
REQ-025 SHALL discard the first partial word after reset; no frame is pushed until one full left word has been stored.
REQ-026 SHALL drop a frame whose push finds the FIFO full, set ro_fifo_overrun, and leave FIFO contents unchanged.
REQ-027 SHALL transfer filt_data only in a cycle where filt_rts=1 and filt_rtr=1, in FIFO order.
REQ-028 SHALL hold filt_data stable while filt_rts=1 and filt_rtr=0.
REQ-029 SHALL assert filt_rts no later than 2 clk cycles after a push into an empty FIFO.
REQ-030 SHALL support push and pop in the same cycle on a full FIFO without an overrun.
REQ-031 SHALL give set priority over clear when the set condition and trig_* coincide in the same cycle, for each sticky flag.
REQ-032 SHALL size the FIFO at 8 entries of 32 bits.

Reset
REQ-033 SHALL on rst_n=0 immediately clear shift register, bit counter, ws_prev, holding registers, left_valid, FIFO pointers, ro_fifo_overrun, ro_frame_err and filt_rts; filt_data SHALL read 0.
REQ-034 SHALL after a reset mid-frame restart alignment per REQ-025 with no stale data delivered.

Structure
REQ-035 SHALL place the word width (16), FIFO width (32) and FIFO address width (3) as constants in the shared audio package.
REQ-036 SHALL implement the serial-to-parallel logic (REQ-015..REQ-025) as one sub-module named deserializer.
REQ-037 SHALL instantiate the existing shared fifo with parameters (32, 3).

Verification
REQ-038 Bench SHALL cover: 3 I2S frames L=0xA5C3/R=0x1234, filt_rtr=1 -> filt_data sequence 0xA5C31234 x3 (first one dropped if partial), no flags.
REQ-039 Bench SHALL cover: filt_rtr=0, 9 complete frames -> 8 held, 9th dropped, ro_fifo_overrun=1; trig_fifo_overrun pulse -> 0.
REQ-040 Bench SHALL cover: left word of 15 bits -> ro_frame_err=1, that frame not delivered, next good frame delivered.
REQ-041 Bench SHALL cover: trig_fifo_overrun coincident with overrun set condition -> flag remains 1.
REQ-042 Bench SHALL cover: rst_n low mid right word with 3 frames queued -> filt_rts=0 next cycle, no stale output after release.
REQ-043 Bench SHALL cover: FIFO full, filt_rtr=1 and push same cycle -> occupancy stays 8, no overrun.
